// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//
// First-word-fall-through byte FIFO between the host write port and the UART
// transmitter's valid/ready input. The host pushes one word per cycle with
// wr_en and watches full/almost_full. The transmitter sees the head word on
// tx_data with tx_valid and pops it with tx_ready.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   wr_data       host write data
//   wr_en         host write strobe, one word per cycle
//   full          occupancy == DEPTH
//   almost_full   occupancy >= ALMOST_FULL_LEVEL
//   overflow      sticky: a write was dropped because the FIFO was full
//   overflow_clr  synchronous clear for overflow (a new drop wins)
//   tx_data       head-of-FIFO word, 0 when empty
//   tx_valid      FIFO non-empty
//   tx_ready      consumer accepts tx_data this cycle
//   empty         occupancy == 0
//   level         registered occupancy 0..DEPTH (only with UART_TX_FIFO_LEVEL_EN)
//
// Build option: define UART_TX_FIFO_LEVEL_EN to add the level output and the
// occupancy register that drives it. Without it, all status flags come from
// the pointer difference.
//
// DEPTH must be a power of two and at least 2; ALMOST_FULL_LEVEL in 1..DEPTH.

module uart_tx_fifo #(
    parameter int unsigned DATA_WIDTH        = 8,
    parameter int unsigned DEPTH             = 16,
    parameter int unsigned ALMOST_FULL_LEVEL = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  overflow_clr,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  empty
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0] level
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [PW-1:0] AF_LVL  = PW'(ALMOST_FULL_LEVEL);

    // Storage is never reset; only the pointers define what is valid.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;

    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          wr_accept;
    logic          rd_accept;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    // ------------------------------------------------------------------
    // Status flags: functions of registered state only
    // ------------------------------------------------------------------
`ifdef UART_TX_FIFO_LEVEL_EN
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    logic [PW-1:0] count_q, count_d;

    always_comb begin
        full        = (count_q == DEPTH_P);
        empty       = (count_q == '0);
        almost_full = (count_q >= AF_LVL);
    end

    assign level = count_q;
`else
    logic [PW-1:0] occupancy;

    // Modular difference is exact because pointers wrap at 2*DEPTH.
    assign occupancy = wr_ptr_q - rd_ptr_q;

    always_comb begin
        full        = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        empty       = (wr_ptr_q == rd_ptr_q);
        almost_full = (occupancy >= AF_LVL);
    end
`endif

    assign tx_valid = ~empty;
    assign overflow = overflow_q;

    // Fall-through head word; forced to 0 so stale storage never shows.
    always_comb begin
        tx_data = '0;
        if (!empty) begin
            tx_data = mem[rd_idx];
        end
    end

    // ------------------------------------------------------------------
    // Handshakes and next state
    // ------------------------------------------------------------------
    // full is pre-edge state, so a write into a full FIFO is dropped even if
    // a read frees a slot on the same edge.
    assign wr_accept = wr_en & ~full;
    assign rd_accept = tx_valid & tx_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_comb begin
        overflow_d = overflow_q;
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

`ifdef UART_TX_FIFO_LEVEL_EN
    always_comb begin
        count_d = count_q;
        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase
    end
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef UART_TX_FIFO_LEVEL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_idx] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    logic       clk;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic       overflow_clr;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       empty;
`ifdef UART_TX_FIFO_LEVEL_EN
    logic [4:0] level;
`endif

    uart_tx_fifo #(
        .DATA_WIDTH        (8),
        .DEPTH             (16),
        .ALMOST_FULL_LEVEL (12)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .full         (full),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .empty        (empty)
`ifdef UART_TX_FIFO_LEVEL_EN
        ,
        .level        (level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_level(input string name, input int exp);
`ifdef UART_TX_FIFO_LEVEL_EN
        chk(name, 32'(level), 32'(exp));
`else
        if (exp < 0) $display("bad level %s", name);
`endif
    endtask

    // One clock: apply inputs, take the edge, sample 1 time unit later, idle inputs.
    task automatic cyc(input logic we, input logic [7:0] d, input logic rdy, input logic clr);
        wr_en        = we;
        wr_data      = d;
        tx_ready     = rdy;
        overflow_clr = clr;
        @(posedge clk);
        #1;
        wr_en        = 1'b0;
        wr_data      = 8'h00;
        tx_ready     = 1'b0;
        overflow_clr = 1'b0;
    endtask

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       tx_ready;
        logic       clr;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_full;
        logic       e_af;
        logic       e_empty;
        logic       e_ovf;
    } vec_t;

    vec_t vecs [16];

    initial begin
        reset        = 1'b1;
        wr_en        = 1'b0;
        wr_data      = 8'h00;
        tx_ready     = 1'b0;
        overflow_clr = 1'b0;

        // Table: write A5, hold 10 cycles, pop, then edge cases around empty.
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 1; i <= 10; i++) begin
            vecs[i] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
        end
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        // Ready while empty: no read, write is still stored.
        vecs[12] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
        // Simultaneous write and read with one entry.
        vecs[13] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};

        // ---------------- reset and idle ----------------
        #2;
        chk("in_reset_valid", 32'(tx_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("idle_empty", 32'(empty), 32'd1);
        chk("idle_valid", 32'(tx_valid), 32'd0);
        chk("idle_full", 32'(full), 32'd0);
        chk("idle_af", 32'(almost_full), 32'd0);
        chk("idle_ovf", 32'(overflow), 32'd0);
        chk("idle_data", 32'(tx_data), 32'd0);
        chk_level("idle_level", 0);

        // ---------------- table vectors ----------------
        for (int i = 0; i < 16; i++) begin
            cyc(vecs[i].wr_en, vecs[i].wr_data, vecs[i].tx_ready, vecs[i].clr);
            chk($sformatf("vec%0d_valid", i), 32'(tx_valid), 32'(vecs[i].e_valid));
            chk($sformatf("vec%0d_data", i), 32'(tx_data), 32'(vecs[i].e_data));
            chk($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].e_full));
            chk($sformatf("vec%0d_af", i), 32'(almost_full), 32'(vecs[i].e_af));
            chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].e_empty));
            chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].e_ovf));
        end

        // ---------------- fill, overflow, drain ----------------
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
            chk($sformatf("fill%0d_af", i), 32'(almost_full), 32'(i + 1 >= 12));
            chk($sformatf("fill%0d_full", i), 32'(full), 32'(i == 15));
        end
        chk_level("fill_level", 16);
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("drop_ovf", 32'(overflow), 32'd1);
        chk("drop_full", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_valid", i), 32'(tx_valid), 32'd1);
            chk($sformatf("drain%0d_data", i), 32'(tx_data), 32'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_ovf_sticky", 32'(overflow), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow), 32'd0);

        // ---------------- steady-state streaming at occupancy 8 ----------------
        for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            chk($sformatf("stream%0d_data", k), 32'(tx_data), 32'(k));
            cyc(1'b1, 8'(k + 8), 1'b1, 1'b0);
            chk($sformatf("stream%0d_empty", k), 32'(empty), 32'd0);
            chk_level($sformatf("stream%0d_level", k), 8);
        end
        chk("stream_af", 32'(almost_full), 32'd0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("sdrain%0d_data", i), 32'(tx_data), 32'(40 + i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("sdrain_empty", 32'(empty), 32'd1);

        // ---------------- full with simultaneous read/write ----------------
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        chk("f2_full", 32'(full), 32'd1);
        cyc(1'b1, 8'h99, 1'b1, 1'b0);
        chk("rw_full_ovf", 32'(overflow), 32'd1);
        chk("rw_full_notfull", 32'(full), 32'd0);
        chk("rw_full_head", 32'(tx_data), 32'h41);
        chk_level("rw_full_level", 15);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        chk("rw_clr_ovf", 32'(overflow), 32'd0);
        cyc(1'b1, 8'h77, 1'b0, 1'b0);
        chk("refill_full", 32'(full), 32'd1);
        chk("refill_ovf", 32'(overflow), 32'd0);
        cyc(1'b1, 8'h88, 1'b0, 1'b1);
        chk("set_wins_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("f2drain%0d_data", i), 32'(tx_data),
                (i < 15) ? 32'(8'h41 + i) : 32'h77);
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("f2drain_empty", 32'(empty), 32'd1);

        // ---------------- reset mid-drain ----------------
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_rst_head", 32'(tx_data), 32'h52);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", 32'(tx_valid), 32'd0);
        chk("async_rst_empty", 32'(empty), 32'd1);
        chk("async_rst_data", 32'(tx_data), 32'd0);
        chk("async_rst_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        chk_level("post_rst_level", 0);
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("post_rst_data", 32'(tx_data), 32'h3C);
        chk("post_rst_valid", 32'(tx_valid), 32'd1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_empty", 32'(empty), 32'd1);
        chk("post_rst_nostale", 32'(tx_data), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Synchronous first-word-fall-through FIFO that buffers host bytes ahead of the UART transmit path. The host side is a simple write strobe with full/almost-full backpressure. The UART side presents tx_data/tx_valid and consumes on tx_ready, matching the transmitter's valid/ready handshake. Sits directly upstream of the UART top-level transmit inputs, letting software burst-write frames without polling per byte.

Parameters:
DATA_WIDTH, 8, width of each stored word and of tx_data
DEPTH, 16, number of entries; must be a power of 2, at least 2
ALMOST_FULL_LEVEL, 12, occupancy at or above which almost_full asserts; range 1..DEPTH

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
wr_data  input  DATA_WIDTH  host write data
wr_en  input  1  host write strobe; one word per cycle when high
full  output  1  occupancy == DEPTH
almost_full  output  1  occupancy >= ALMOST_FULL_LEVEL
overflow  output  1  sticky flag: a write was dropped because FIFO was full
overflow_clr  input  1  clears overflow (synchronous)
tx_data  output  DATA_WIDTH  head-of-FIFO word (FWFT)
tx_valid  output  1  FIFO non-empty
tx_ready  input  1  consumer accepts tx_data this cycle
empty  output  1  occupancy == 0

Behaviour:
- Reset (async assert, sync release by design): wr_ptr=0, rd_ptr=0, count=0, overflow=0; outputs: empty=1, tx_valid=0, full=0, almost_full=0, tx_data=0 (storage not cleared).
- Pointers are log2(DEPTH)+1 bits; extra MSB is the wrap bit. Equal pointers = empty. Equal index with differing MSB = full. Pointers wrap naturally modulo 2*DEPTH.
- Write accepted = wr_en && !full; stores wr_data at wr_ptr index, wr_ptr++.
- Read accepted = tx_valid && tx_ready; rd_ptr++.
- full, empty, almost_full and tx_valid are registered or derived from registered pointers only, with no combinational path from wr_en or tx_ready.
- tx_data = mem[rd_ptr index] (combinational read of registered storage); it is 0 when empty.
- Latency:
  - A write into an empty FIFO at edge N gives tx_valid=1 and tx_data=that word after edge N (visible in cycle N+1).
  - A read at edge N presents the next word in cycle N+1.
- Simultaneous write and read (not full, not empty): both occur; count is unchanged.
- Write while full: dropped, even if a read is accepted in the same cycle. full is evaluated on pre-edge state. overflow sets to 1.
- Read while empty: tx_valid=0, so no transfer. A write to an empty FIFO in the same cycle is stored normally.
- tx_ready while tx_valid=0: ignored.
- overflow_clr and a new overflow event in the same cycle: set wins, overflow stays 1.
- tx_data must remain stable while tx_valid=1 and tx_ready=0.
- Reset mid-operation: all contents are discarded immediately. tx_valid drops asynchronously with reset.
- almost_full is recomputed from count each cycle. DEPTH=ALMOST_FULL_LEVEL makes it equal full.

Optional Feature:
UART_TX_FIFO_LEVEL_EN
- Defined: adds output port level [log2(DEPTH):0], the registered occupancy (0..DEPTH). Reset value is 0. It updates on the same edge as the pointers.
- Undefined: the port is absent and no extra count register is built. full, empty and almost_full are derived from pointer difference only.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then idle 5 cycles -> empty=1, tx_valid=0, full=0, almost_full=0, overflow=0, tx_data=0.
- Write 0xA5 with tx_ready=0 -> next cycle tx_valid=1, tx_data=0xA5. Hold tx_ready=0 for 10 cycles -> tx_data stays 0xA5. Pulse tx_ready -> empty=1 next cycle.
- Write 0x00..0x0F (16 words), tx_ready=0 -> almost_full=1 after 12th write, full=1 after 16th. 17th write 0xFF -> dropped, overflow=1. Drain -> order 0x00..0x0F, 0xFF never appears.
- Fill to 8, then 40 cycles of simultaneous wr_en=1 and tx_ready=1 with an incrementing pattern -> occupancy stays 8 (level=8 if UART_TX_FIFO_LEVEL_EN), output sequence in order, pointers wrap twice with no corruption.
- Full FIFO, wr_en=1 and tx_ready=1 same cycle -> read occurs, write dropped, overflow=1, full=0 next cycle. Then overflow_clr=1 -> overflow=0. overflow_clr together with a dropped write -> overflow remains 1.
- Write 5 words, assert reset mid-drain -> tx_valid=0 and empty=1 immediately. After release, write 0x3C -> tx_data=0x3C; no stale data emerges.
